case_3_mul_arb: RTL and testbench

Round-robin controller that shares one signed 13x10 multiplier among NUM_REQ requesters. Each requester presents operands with a valid/ready handshake; the block grants one request per cycle, drives the shared multiplier, and returns the 16-bit truncated product with the requester's index on a single registered response channel. It sits between the case_3 loop-body requesters and the single multiplier resource that synthesis allots to case_3.

---
 rtl/case_3_mul_arb_pkg.sv | 22 ++
 rtl/case_3_mul_arb_if.sv | 38 +++
 rtl/case_3_mul_rr_pick.sv | 40 ++++
 rtl/case_3_mul_arb.sv | 149 ++++++++++++++
 tb/tb_case_3_mul_arb.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/case_3_mul_arb_pkg.sv
// case_3_mul_arb_pkg
//   Shared constants and helpers for the case_3 multiplier arbiter.
//   - A_W / B_W / P_W : signed operand A, operand B and truncated product widths.
//   - out_state_e     : output register occupancy (EMPTY / FULL).
//   - rr_next()       : rotate a requester index to the next one, wrapping at n.
package case_3_mul_arb_pkg;

  localparam int A_W = 13;
  localparam int B_W = 10;
  localparam int P_W = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic int rr_next(input int idx, input int n);
    if (idx + 1 >= n) return 0;
    return idx + 1;
  endfunction

endpackage

// File: rtl/case_3_mul_arb_if.sv
// case_3_mul_arb_if
//   Request/response bundle between the case_3 requesters and the shared
//   multiplier arbiter.
//   - req_valid/req_ready : per-requester handshake (one bit per requester).
//   - req_a/req_b         : packed operands, requester i at [i*W +: W].
//   - rsp_valid/rsp_ready : single response handshake.
//   - rsp_id/rsp_p        : owning requester index and truncated product.
//   Modports: master (requester/consumer side), slave (arbiter side).
interface case_3_mul_arb_if
  import case_3_mul_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = A_W,
  parameter int B_WIDTH  = B_W,
  parameter int P_WIDTH  = P_W,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic [P_WIDTH-1:0]         rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );

endinterface

// File: rtl/case_3_mul_rr_pick.sv
// case_3_mul_rr_pick
//   Combinational round-robin picker. Scans requesters starting at ptr and
//   wrapping modulo NUM_REQ; the first valid one wins.
//   - req_valid : per-requester valid.
//   - ptr       : index with highest priority this cycle.
//   - grant     : one-hot winner (all zero when nobody is valid).
//   - gnt_idx   : binary index of the winner.
//   - any       : at least one requester is valid.
module case_3_mul_rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] gnt_idx,
  output logic                any
);

  always_comb begin
    int                  idx;
    logic [ID_WIDTH-1:0] idx_w;
    grant   = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = ID_WIDTH'(idx);
      if (!any && req_valid[idx_w]) begin
        any          = 1'b1;
        grant[idx_w] = 1'b1;
        gnt_idx      = idx_w;
      end
    end
  end

endmodule

// File: rtl/case_3_mul_arb.sv
// case_3_mul_arb
//   Shares one signed A_WIDTH x B_WIDTH multiplier among NUM_REQ requesters.
//   One request is accepted per cycle in round-robin order; the low P_WIDTH
//   bits of the product are returned with the requester index on a single
//   registered response channel.
//   Ports:
//   - ap_clk : clock, rising edge.
//   - ap_rst : synchronous active-high reset.
//   - bus    : case_3_mul_arb_if.slave (request and response handshakes).
//   Build option:
//   - CASE_3_MUL_ARB_PIPE_EN : adds an operand stage ahead of the multiplier
//     (latency 2 instead of 1, throughput unchanged).
module case_3_mul_arb
  import case_3_mul_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = A_W,
  parameter int B_WIDTH  = B_W,
  parameter int P_WIDTH  = P_W,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input logic              ap_clk,
  input logic              ap_rst,
  case_3_mul_arb_if.slave  bus
);

  // Full-precision signed product, wrapped to P_WIDTH (no saturation).
  function automatic logic signed [P_WIDTH-1:0] wrap_product(
    input logic signed [A_WIDTH-1:0] a,
    input logic signed [B_WIDTH-1:0] b
  );
    logic signed [A_WIDTH+B_WIDTH-1:0] full;
    full = (A_WIDTH+B_WIDTH)'(a) * (A_WIDTH+B_WIDTH)'(b);
    return full[P_WIDTH-1:0];
  endfunction

  logic [NUM_REQ-1:0]         grant;
  logic [ID_WIDTH-1:0]        gnt_idx;
  logic                       any;
  logic                       adv_out;
  logic                       acc_en;
  logic                       accept;
  logic                       load_out;
  logic signed [A_WIDTH-1:0]  a_sel;
  logic signed [B_WIDTH-1:0]  b_sel;
  logic signed [A_WIDTH-1:0]  op_a;
  logic signed [B_WIDTH-1:0]  op_b;
  logic [ID_WIDTH-1:0]        op_id;

  logic [ID_WIDTH-1:0]        ptr_q, ptr_d;
  out_state_e                 out_st_q, out_st_d;
  logic [ID_WIDTH-1:0]        rsp_id_q, rsp_id_d;
  logic signed [P_WIDTH-1:0]  rsp_p_q, rsp_p_d;

`ifdef CASE_3_MUL_ARB_PIPE_EN
  logic                       adv_s1;
  logic                       s1_vld_q, s1_vld_d;
  logic signed [A_WIDTH-1:0]  s1_a_q, s1_a_d;
  logic signed [B_WIDTH-1:0]  s1_b_q, s1_b_d;
  logic [ID_WIDTH-1:0]        s1_id_q, s1_id_d;
`endif

  case_3_mul_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .gnt_idx   (gnt_idx),
    .any       (any)
  );

  assign a_sel = bus.req_a[int'(gnt_idx)*A_WIDTH +: A_WIDTH];
  assign b_sel = bus.req_b[int'(gnt_idx)*B_WIDTH +: B_WIDTH];

  always_comb begin
    adv_out = (out_st_q == OUT_EMPTY) || bus.rsp_ready;
`ifdef CASE_3_MUL_ARB_PIPE_EN
    adv_s1 = !s1_vld_q || adv_out;
    acc_en = adv_s1;
`else
    acc_en = adv_out;
`endif
    // Gating with ap_rst keeps requests pending during reset from being
    // granted until the first cycle after release.
    accept        = acc_en && any && !ap_rst;
    bus.req_ready = accept ? grant : '0;
    ptr_d         = accept ? ID_WIDTH'(rr_next(int'(gnt_idx), NUM_REQ)) : ptr_q;

    // Operand stage (pipelined build) feeding the multiplier.
`ifdef CASE_3_MUL_ARB_PIPE_EN
    s1_vld_d = accept ? 1'b1 : (adv_out ? 1'b0 : s1_vld_q);
    s1_a_d   = accept ? a_sel   : s1_a_q;
    s1_b_d   = accept ? b_sel   : s1_b_q;
    s1_id_d  = accept ? gnt_idx : s1_id_q;
    load_out = adv_out && s1_vld_q;
    op_a     = s1_a_q;
    op_b     = s1_b_q;
    op_id    = s1_id_q;
`else
    load_out = accept;
    op_a     = a_sel;
    op_b     = b_sel;
    op_id    = gnt_idx;
`endif

    // Output register stage: product and tag captured only on load.
    out_st_d = out_st_q;
    case (out_st_q)
      OUT_EMPTY: if (load_out) out_st_d = OUT_FULL;
      OUT_FULL:  if (!load_out && bus.rsp_ready) out_st_d = OUT_EMPTY;
      default:   out_st_d = OUT_EMPTY;
    endcase
    rsp_p_d  = load_out ? wrap_product(op_a, op_b) : rsp_p_q;
    rsp_id_d = load_out ? op_id : rsp_id_q;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr_q    <= '0;
      out_st_q <= OUT_EMPTY;
      rsp_id_q <= '0;
      rsp_p_q  <= '0;
`ifdef CASE_3_MUL_ARB_PIPE_EN
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_id_q  <= '0;
`endif
    end else begin
      ptr_q    <= ptr_d;
      out_st_q <= out_st_d;
      rsp_id_q <= rsp_id_d;
      rsp_p_q  <= rsp_p_d;
`ifdef CASE_3_MUL_ARB_PIPE_EN
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_id_q  <= s1_id_d;
`endif
    end
  end

  assign bus.rsp_valid = (out_st_q == OUT_FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_p     = rsp_p_q;

endmodule

// File: tb/tb_case_3_mul_arb.sv
// tb_case_3_mul_arb
//   Directed bench for case_3_mul_arb. Inputs change 2 time units after the
//   rising edge and outputs are sampled 1 unit later, mid-cycle.
//   Default operands: r0 100*-3 -> FED4, r1 -1*-1 -> 0001,
//   r2 4095*511 -> EE01, r3 -5*6 -> FFE2.
module tb_case_3_mul_arb;

`ifdef CASE_3_MUL_ARB_PIPE_EN
  localparam int LAT  = 2;
  localparam bit PIPE = 1'b1;
`else
  localparam int LAT  = 1;
  localparam bit PIPE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  case_3_mul_arb_if #(.NUM_REQ(4)) bus ();

  case_3_mul_arb #(.NUM_REQ(4)) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[i*13 +: 13] = 13'(a);
    bus.req_b[i*10 +: 10] = 10'(b);
  endtask

  task automatic set_defaults();
    set_op(0, 100, -3);
    set_op(1, -1, -1);
    set_op(2, 4095, 511);
    set_op(3, -5, 6);
  endtask

  function automatic logic [15:0] exp_prod(input int i);
    case (i)
      0:       return 16'hFED4;
      1:       return 16'h0001;
      2:       return 16'hEE01;
      default: return 16'hFFE2;
    endcase
  endfunction

  // One request from requester idx, then watch the response arrive LAT later.
  task automatic single(input string tag, input int idx, input int a, input int b,
                        input logic [15:0] ep);
    set_op(idx, a, b);
    bus.req_valid = 4'(1 << idx);
    bus.rsp_ready = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(bus.req_ready), 32'(1 << idx));
    next_cyc();
    bus.req_valid = 4'b0000;
    for (int k = 1; k <= LAT; k++) begin
      #1;
      if (k < LAT) begin
        check($sformatf("%s_early%0d", tag, k), 32'(bus.rsp_valid), 32'd0);
      end else begin
        check({tag, "_vld"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_id"},  32'(bus.rsp_id),    32'(idx));
        check({tag, "_p"},   32'(bus.rsp_p),     32'(ep));
      end
      next_cyc();
    end
  endtask

  // Hold vld for n cycles with rsp_ready=1; gseq[2k+:2] is the k-th grant.
  task automatic stream(input string tag, input logic [3:0] vld, input int n,
                        input logic [15:0] gseq);
    for (int k = 0; k < n + LAT; k++) begin
      bus.req_valid = (k < n) ? vld : 4'b0000;
      bus.rsp_ready = 1'b1;
      #1;
      check($sformatf("%s_gnt%0d", tag, k), 32'(bus.req_ready),
            (k < n) ? (32'd1 << gseq[2*k +: 2]) : 32'd0);
      if (k >= LAT) begin
        int j;
        j = int'(gseq[2*(k-LAT) +: 2]);
        check($sformatf("%s_vld%0d", tag, k), 32'(bus.rsp_valid), 32'd1);
        check($sformatf("%s_id%0d", tag, k),  32'(bus.rsp_id),    32'(j));
        check($sformatf("%s_p%0d", tag, k),   32'(bus.rsp_p),     32'(exp_prod(j)));
      end
      next_cyc();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    set_defaults();
    next_cyc();
    next_cyc();

    // Reset state, with a request pending that must not be granted.
    bus.req_valid = 4'b0001;
    #1;
    check("rst_vld", 32'(bus.rsp_valid), 32'd0);
    check("rst_p",   32'(bus.rsp_p),     32'd0);
    check("rst_id",  32'(bus.rsp_id),    32'd0);
    check("rst_rdy", 32'(bus.req_ready), 32'd0);
    rst           = 1'b0;
    bus.req_valid = 4'b0000;
    next_cyc();

    // Fairness: grants 0,1,2,3,0,1,2,3 starting from ptr 0.
    stream("fair", 4'b1111, 8, 16'hE4E4);

    // Single requester (ptr ends at 1).
    single("single", 0, 100, -3, 16'hFED4);

    // Pointer skip from ptr 1 with r3 and r0 valid: grant 3 then 0.
    stream("skip", 4'b1001, 2, 16'h0003);

    // Wrap cases on requester 2 (ptr ends at 3).
    single("wrap_pos", 2, 4095, 511, 16'hEE01);
    single("wrap_neg", 2, -4096, -512, 16'h0000);
    set_defaults();

    // Backpressure: fill output with r3, then stall 3 cycles.
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_acc", 32'(bus.req_ready), 32'h8);
    next_cyc();
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    for (int k = 1; k < LAT; k++) next_cyc();
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = 4'b0001;
      bus.rsp_ready = 1'b0;
      #1;
      check($sformatf("bp_vld%0d", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp_id%0d", c),  32'(bus.rsp_id),    32'd3);
      check($sformatf("bp_p%0d", c),   32'(bus.rsp_p),     32'hFFE2);
      check($sformatf("bp_rdy%0d", c), 32'(bus.req_ready),
            (PIPE && c == 0) ? 32'h1 : 32'h0);
      next_cyc();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_rel_p",   32'(bus.rsp_p),     32'hFFE2);
    check("bp_rel_rdy", 32'(bus.req_ready), 32'h1);
    next_cyc();
    bus.req_valid = 4'b0000;
    #1;
    check("bp_new_vld", 32'(bus.rsp_valid), 32'd1);
    check("bp_new_id",  32'(bus.rsp_id),    32'd0);
    check("bp_new_p",   32'(bus.rsp_p),     32'hFED4);
    next_cyc();
    if (PIPE) begin
      #1;
      check("bp_new2_id", 32'(bus.rsp_id), 32'd0);
      check("bp_new2_p",  32'(bus.rsp_p),  32'hFED4);
      next_cyc();
    end

    // Reset mid-operation (ptr at 1): hold r1's product, then reset.
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    #1;
    check("mid_acc", 32'(bus.req_ready), 32'h2);
    next_cyc();
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    for (int k = 1; k < LAT; k++) next_cyc();
    #1;
    check("mid_full_id", 32'(bus.rsp_id), 32'd1);
    check("mid_full_p",  32'(bus.rsp_p),  32'h0001);
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    check("mid_rst_rdy", 32'(bus.req_ready), 32'd0);
    next_cyc();
    #1;
    check("mid_post_vld", 32'(bus.rsp_valid), 32'd0);
    check("mid_post_p",   32'(bus.rsp_p),     32'd0);
    check("mid_post_id",  32'(bus.rsp_id),    32'd0);
    rst           = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    check("mid_first_gnt", 32'(bus.req_ready), 32'h1);
    next_cyc();
    bus.req_valid = 4'b0000;
    for (int k = 1; k <= LAT; k++) begin
      #1;
      if (k == LAT) begin
        check("mid_first_id", 32'(bus.rsp_id), 32'd0);
        check("mid_first_p",  32'(bus.rsp_p),  32'hFED4);
      end
      next_cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
